// File: rtl/updown_ptr_counter_if.sv
// Control and status bundle for the LIFO pointer counter.
// E and Load are per-cycle strobes: each cycle they are high at a rising edge
// is one request. There is no ready back-pressure; the counter accepts every request.
interface updown_ptr_counter_if #(
   parameter int WIDTH = 5
);
   logic             E;
   logic             D;
   logic             Load;
   logic [WIDTH-1:0] Din;
   logic             ErrClr;
   logic [WIDTH-1:0] Y;
   logic             carry;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             unf;

   modport master (
      output E, D, Load, Din, ErrClr,
      input  Y, carry, full, empty, ovf, unf
   );

   modport slave (
      input  E, D, Load, Din, ErrClr,
      output Y, carry, full, empty, ovf, unf
   );
endinterface

// File: rtl/updown_ptr_counter.sv
// Parametrised up/down stack-pointer counter with wrap or saturate mode,
// clamped parallel load, registered full/empty/carry and sticky ovf/unf flags.
module updown_ptr_counter #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 32,
   parameter int SAT   = 0
) (
   input logic                CLK,
   input logic                Reset,
   updown_ptr_counter_if.slave bus
);
   // One extra bit so DEPTH-1 and Y+1 never alias when DEPTH == 2**WIDTH.
   localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(DEPTH - 1);

   logic [WIDTH-1:0] y_q, y_d;
   logic             carry_q, carry_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH:0] y_ext;
   logic [WIDTH:0] y_ext_d;
   logic [WIDTH:0] din_ext;
   logic           at_max;
   logic           at_zero;

   assign y_ext   = {1'b0, y_q};
   assign din_ext = {1'b0, bus.Din};
   assign at_max  = (y_ext == MAX_W);
   assign at_zero = (y_q == '0);

   always_comb begin
      y_ext_d = y_ext;
      carry_d = 1'b0;
      ovf_d   = ovf_q & ~bus.ErrClr;
      unf_d   = unf_q & ~bus.ErrClr;

      if (bus.Load) begin
         y_ext_d = (din_ext > MAX_W) ? MAX_W : din_ext;
      end else if (bus.E) begin
         if (!bus.D) begin
            if (at_max) begin
               if (SAT != 0) begin
                  ovf_d = 1'b1;
               end else begin
                  y_ext_d = '0;
                  carry_d = 1'b1;
               end
            end else begin
               y_ext_d = y_ext + 1'b1;
            end
         end else begin
            if (at_zero) begin
               if (SAT != 0) begin
                  unf_d = 1'b1;
               end else begin
                  y_ext_d = MAX_W;
                  carry_d = 1'b1;
               end
            end else begin
               y_ext_d = y_ext - 1'b1;
            end
         end
      end

      // Flags decode the next count so they line up with Y.
      y_d     = y_ext_d[WIDTH-1:0];
      full_d  = (y_ext_d == MAX_W);
      empty_d = (y_ext_d == '0);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         y_q     <= '0;
         carry_q <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         y_q     <= y_d;
         carry_q <= carry_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign bus.Y     = y_q;
   assign bus.carry = carry_q;
   assign bus.full  = full_q;
   assign bus.empty = empty_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule

// File: tb/tb_updown_ptr_counter.sv
// Drives four counter configurations with one shared stimulus stream and
// checks each against an independent behavioural model through a scoreboard queue.
module tb_updown_ptr_counter;
   localparam int W  = 10;
   localparam int ND = 4;

   // Configurations: a=(5,32,wrap) b=(5,20,wrap) c=(5,20,sat) d=(4,16,wrap)
   int cfg_w[ND]     = '{5, 5, 5, 4};
   int cfg_depth[ND] = '{32, 20, 20, 16};
   int cfg_sat[ND]   = '{0, 0, 1, 0};

   logic       clk;
   logic       rst_r;
   logic       e_r, d_r, load_r, clr_r;
   logic [4:0] din_r;

   int errors = 0;
   int checks = 0;
   int step_no = 0;

   int m_y[ND];
   bit m_ovf[ND];
   bit m_unf[ND];

   logic [W-1:0] exp_q[$];

   updown_ptr_counter_if #(.WIDTH(5)) if_a ();
   updown_ptr_counter_if #(.WIDTH(5)) if_b ();
   updown_ptr_counter_if #(.WIDTH(5)) if_c ();
   updown_ptr_counter_if #(.WIDTH(4)) if_d ();

   assign if_a.E = e_r;  assign if_a.D = d_r;  assign if_a.Load = load_r;
   assign if_a.Din = din_r;       assign if_a.ErrClr = clr_r;
   assign if_b.E = e_r;  assign if_b.D = d_r;  assign if_b.Load = load_r;
   assign if_b.Din = din_r;       assign if_b.ErrClr = clr_r;
   assign if_c.E = e_r;  assign if_c.D = d_r;  assign if_c.Load = load_r;
   assign if_c.Din = din_r;       assign if_c.ErrClr = clr_r;
   assign if_d.E = e_r;  assign if_d.D = d_r;  assign if_d.Load = load_r;
   assign if_d.Din = din_r[3:0];  assign if_d.ErrClr = clr_r;

   updown_ptr_counter #(.WIDTH(5), .DEPTH(32), .SAT(0)) u_a (.CLK(clk), .Reset(rst_r), .bus(if_a));
   updown_ptr_counter #(.WIDTH(5), .DEPTH(20), .SAT(0)) u_b (.CLK(clk), .Reset(rst_r), .bus(if_b));
   updown_ptr_counter #(.WIDTH(5), .DEPTH(20), .SAT(1)) u_c (.CLK(clk), .Reset(rst_r), .bus(if_c));
   updown_ptr_counter #(.WIDTH(4), .DEPTH(16), .SAT(0)) u_d (.CLK(clk), .Reset(rst_r), .bus(if_d));

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   function automatic logic [W-1:0] observe(input int i);
      logic [W-1:0] o;
      case (i)
         0: o = {if_a.Y, if_a.carry, if_a.full, if_a.empty, if_a.ovf, if_a.unf};
         1: o = {if_b.Y, if_b.carry, if_b.full, if_b.empty, if_b.ovf, if_b.unf};
         2: o = {if_c.Y, if_c.carry, if_c.full, if_c.empty, if_c.ovf, if_c.unf};
         default: o = {1'b0, if_d.Y, if_d.carry, if_d.full, if_d.empty, if_d.ovf, if_d.unf};
      endcase
      return o;
   endfunction

   // Behavioural model: computes what every configuration should show after this edge.
   task automatic model_push(input bit rst, ld, e, d, input int din, input bit clr);
      for (int i = 0; i < ND; i++) begin
         int mx, dv, y;
         bit cy, fl, em;
         mx = cfg_depth[i] - 1;
         dv = din & ((1 << cfg_w[i]) - 1);
         y  = m_y[i];
         cy = 1'b0;
         if (rst) begin
            y = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
            fl = 1'b0; em = 1'b1;
         end else begin
            if (clr) begin
               m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
            end
            if (ld) begin
               y = (dv > mx) ? mx : dv;
            end else if (e && !d) begin
               if (y == mx) begin
                  if (cfg_sat[i] != 0) m_ovf[i] = 1'b1;
                  else begin y = 0; cy = 1'b1; end
               end else y = y + 1;
            end else if (e && d) begin
               if (y == 0) begin
                  if (cfg_sat[i] != 0) m_unf[i] = 1'b1;
                  else begin y = mx; cy = 1'b1; end
               end else y = y - 1;
            end
            fl = (y == mx);
            em = (y == 0);
         end
         m_y[i] = y;
         exp_q.push_back({5'(y), cy, fl, em, m_ovf[i], m_unf[i]});
      end
   endtask

   // driver task: apply one edge of stimulus, then score every DUT
   task automatic step(input bit rst, ld, e, d, input int din, input bit clr);
      @(negedge clk);
      rst_r = rst; load_r = ld; e_r = e; d_r = d; din_r = 5'(din); clr_r = clr;
      model_push(rst, ld, e, d, din, clr);
      @(posedge clk);
      #1;
      step_no++;
      for (int i = 0; i < ND; i++) begin
         logic [W-1:0] exp_v, obs_v;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty step=%0d dut=%0d", step_no, i);
         end else begin
            exp_v = exp_q.pop_front();
            obs_v = observe(i);
            assert (obs_v === exp_v) else begin
               errors++;
               $error("FAIL step%0d_dut%0d observed Y/c/f/e/o/u=%0d/%b required=%0d/%b",
                      step_no, i, obs_v[9:5], obs_v[4:0], exp_v[9:5], exp_v[4:0]);
            end
         end
      end
   endtask

   initial begin
      rst_r = 1'b1; e_r = 1'b0; d_r = 1'b0; load_r = 1'b0; din_r = '0; clr_r = 1'b0;
      for (int i = 0; i < ND; i++) begin
         m_y[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
      end

      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      // 40 up steps: wrap at 31 (and 19/15 on the smaller configs), saturate on c
      for (int k = 0; k < 40; k++) step(0, 0, 1, 0, 0, 0);
      // load 0 then 3 down steps: borrow to DEPTH-1
      step(0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 25, 0);
      step(0, 0, 0, 0, 0, 0);
      // reset then 22 up steps
      step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 22; k++) step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 1);
      // error set and clear on same edge: set wins
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      // load beats enable on the same edge
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 7, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      // reset beats load, enable and clear
      step(1, 1, 1, 0, 9, 1);
      step(0, 0, 0, 0, 0, 0);
      // alternating around the top/bottom boundary
      step(0, 1, 0, 0, 15, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      // random tail
      for (int k = 0; k < 60; k++) begin
         step((($urandom_range(0, 29)) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
